// File: rtl/datapath_pkg.sv
// Shared datapath definitions: the forwarding-select encoding and default widths
// used by the forwarding/hazard unit, its interface and its per-operand selector.
package datapath_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  // Encoding of the ALU-operand 3:1 mux select; 2'b11 is never produced.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Bus between the pipeline control (master) and fwd_hazard_unit (slave).
// StallCount exists only when STALL_COUNT_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int REG_W = datapath_pkg::REG_W,
  parameter int CNT_W = datapath_pkg::CNT_W
);

  logic             ID_Valid;
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic [REG_W-1:0] EX_Rd;
  logic             EX_RegWrite;
  logic             EX_MemRead;
  logic [REG_W-1:0] MEM_Rd;
  logic             MEM_RegWrite;
  logic             Flush;
  logic             Stall;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic             EX_Valid;
`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] StallCount;
`endif

  modport master (
    output ID_Valid, ID_Rs, ID_Rt, EX_Rd, EX_RegWrite, EX_MemRead,
    output MEM_Rd, MEM_RegWrite, Flush,
    input  Stall, ForwardA, ForwardB, EX_Valid
`ifdef STALL_COUNT_EN
    , input StallCount
`endif
  );

  modport slave (
    input  ID_Valid, ID_Rs, ID_Rt, EX_Rd, EX_RegWrite, EX_MemRead,
    input  MEM_Rd, MEM_RegWrite, Flush,
    output Stall, ForwardA, ForwardB, EX_Valid
`ifdef STALL_COUNT_EN
    , output StallCount
`endif
  );

endinterface

// File: rtl/fwd_hazard_unit_fwd_sel.sv
// Combinational forwarding select for one ALU operand: compares a source index
// against the EX and MEM destinations, EX (newer producer) taking priority.
module fwd_sel
  import datapath_pkg::*;
#(
  parameter int REG_W = datapath_pkg::REG_W
) (
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_regwrite,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_regwrite,
  output fwd_sel_e         o_sel,
  output logic             o_hit_ex
);

  logic w_src_nz;
  logic w_hit_mem;

  // Register 0 is hard-wired to zero, so a write to it is never a real producer.
  assign w_src_nz  = |i_src;
  assign o_hit_ex  = i_ex_regwrite  && (i_ex_rd  == i_src) && w_src_nz;
  assign w_hit_mem = i_mem_regwrite && (i_mem_rd == i_src) && w_src_nz;

  // NOTE: assigning a default before any branch keeps always_comb latch-free.
  always_comb begin
    o_sel = FWD_REG;
    if (o_hit_ex) begin
      o_sel = FWD_EXMEM;
    end else if (w_hit_mem) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Registered forwarding selects and load-use stall/bubble control between ID and EX.
// Optional feature: define STALL_COUNT_EN to add a saturating StallCount output.
module fwd_hazard_unit
  import datapath_pkg::*;
#(
  parameter int REG_W = datapath_pkg::REG_W
) (
  input logic               Clk,
  input logic               Reset_n,
  fwd_hazard_unit_if.slave  bus
);

  fwd_sel_e w_sel_a;
  fwd_sel_e w_sel_b;
  logic     w_hit_ex_a;
  logic     w_hit_ex_b;
  logic     w_hazard;
  logic     w_stall;
  logic     w_bubble;

  fwd_sel_e r_fwd_a;
  fwd_sel_e r_fwd_b;
  logic     r_ex_valid;

  fwd_sel #(.REG_W(REG_W)) u_sel_a (
    .i_src          (bus.ID_Rs),
    .i_ex_rd        (bus.EX_Rd),
    .i_ex_regwrite  (bus.EX_RegWrite),
    .i_mem_rd       (bus.MEM_Rd),
    .i_mem_regwrite (bus.MEM_RegWrite),
    .o_sel          (w_sel_a),
    .o_hit_ex       (w_hit_ex_a)
  );

  fwd_sel #(.REG_W(REG_W)) u_sel_b (
    .i_src          (bus.ID_Rt),
    .i_ex_rd        (bus.EX_Rd),
    .i_ex_regwrite  (bus.EX_RegWrite),
    .i_mem_rd       (bus.MEM_Rd),
    .i_mem_regwrite (bus.MEM_RegWrite),
    .o_sel          (w_sel_b),
    .o_hit_ex       (w_hit_ex_b)
  );

  // A load in EX cannot forward yet; the consumer waits one cycle and then
  // picks the loaded value up from MEM/WB.
  assign w_hazard = bus.ID_Valid && bus.EX_MemRead && (w_hit_ex_a || w_hit_ex_b);
  assign w_stall  = w_hazard && !bus.Flush;
  assign w_bubble = bus.Flush || w_stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ex_valid <= 1'b0;
      r_fwd_a    <= FWD_REG;
      r_fwd_b    <= FWD_REG;
    end else if (w_bubble) begin
      r_ex_valid <= 1'b0;
      r_fwd_a    <= FWD_REG;
      r_fwd_b    <= FWD_REG;
    end else begin
      r_ex_valid <= bus.ID_Valid;
      r_fwd_a    <= bus.ID_Valid ? w_sel_a : FWD_REG;
      r_fwd_b    <= bus.ID_Valid ? w_sel_b : FWD_REG;
    end
  end

  assign bus.Stall    = w_stall;
  assign bus.ForwardA = r_fwd_a;
  assign bus.ForwardB = r_fwd_b;
  assign bus.EX_Valid = r_ex_valid;

`ifdef STALL_COUNT_EN
  logic [$bits(bus.StallCount)-1:0] r_stall_cnt;

  // Saturates rather than wrapping so a long run never reads as few stalls.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.StallCount = r_stall_cnt;
`else
  // Without the counter the stall and forwarding behaviour is unchanged.
`endif

endmodule
